// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO burst reader and its skid buffer.
package fifo_burst_reader_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int SKID_DEPTH = 2;
    localparam int OCC_WIDTH  = $clog2(SKID_DEPTH + 1);
    localparam int STAT_WIDTH = 32;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry valid/ready buffer. An empty buffer passes the incoming word straight through.
module fifo_skid_buf
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  srst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [OCC_WIDTH-1:0]  occupancy
);

    logic [DATA_WIDTH-1:0] mem_data [SKID_DEPTH];
    logic                  mem_last [SKID_DEPTH];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic                  bypass;
    logic                  push;
    logic                  pop_mem;

    assign bypass    = (occupancy == '0);
    assign out_valid = bypass ? in_valid : 1'b1;
    assign out_data  = (bypass && in_valid) ? in_data : mem_data[rd_ptr];
    assign out_last  = out_valid && (bypass ? in_last : mem_last[rd_ptr]);
    // A word presented by bypass and taken in the same cycle is never stored.
    assign push      = in_valid && !(bypass && out_ready);
    assign pop_mem   = !bypass && out_ready;

    // NOTE: the two entries are reset (not left undefined) so m_data reads 0 out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_data  <= '{default: '0};
            mem_last  <= '{default: 1'b0};
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occupancy <= '0;
        end else if (srst) begin
            mem_data  <= '{default: '0};
            mem_last  <= '{default: 1'b0};
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occupancy <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= in_data;
                mem_last[wr_ptr] <= in_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop_mem) rd_ptr <= ~rd_ptr;
            occupancy <= occupancy + OCC_WIDTH'(push) - OCC_WIDTH'(pop_mem);
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a synchronous FIFO in fixed-length bursts onto a valid/ready stream.
// Define FIFO_BURST_READER_STATS_EN to add the stat_bursts / stat_stall counters.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  srst,
    output logic                  fifo_rdreq,
    input  logic [DATA_WIDTH-1:0] fifo_rddata,
    input  logic [ADDR_WIDTH:0]   fifo_rdused,
    input  logic                  fifo_rdempty,
    input  logic                  flush,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy
`ifdef FIFO_BURST_READER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_bursts,
    output logic [STAT_WIDTH-1:0] stat_stall
`endif
);

    localparam int CNT_WIDTH = ADDR_WIDTH + 1;
    localparam int CS_WIDTH  = OCC_WIDTH + 1;
    typedef logic [CNT_WIDTH-1:0] cnt_t;
    localparam cnt_t BURST_LEN_C = cnt_t'(BURST_LEN);

    state_t               state;
    state_t               next_state;
    cnt_t                 blen;
    cnt_t                 issued;
    cnt_t                 sent;
    logic                 inflight;
    logic                 inflight_last;
    logic [OCC_WIDTH-1:0] occupancy;
    logic [CS_WIDTH-1:0]  credit_sum;
    logic                 acc;
    logic                 pop;
    logic                 last_pop;
    logic                 credit_ok;
    logic                 start_full;
    logic                 start_flush;

    assign acc         = fifo_rdreq && !fifo_rdempty;
    assign pop         = m_valid && m_ready;
    assign last_pop    = pop && (sent == blen - cnt_t'(1));
    assign start_full  = (fifo_rdused >= BURST_LEN_C);
    assign start_flush = flush && (fifo_rdused != '0);
    // Words held or still coming back from the FIFO, less the one leaving now.
    assign credit_sum  = CS_WIDTH'(occupancy) + CS_WIDTH'(inflight) - CS_WIDTH'(pop);
    assign credit_ok   = (credit_sum < CS_WIDTH'(SKID_DEPTH));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     state <= IDLE;
        else if (srst) state <= IDLE;
        else           state <= next_state;
    end

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            IDLE:    if (start_full || start_flush) next_state = BURST;
            BURST:   if (last_pop) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        fifo_rdreq = 1'b0;
        busy       = 1'b0;
        if (state == BURST) begin
            busy       = 1'b1;
            fifo_rdreq = (issued < blen) && credit_ok;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blen          <= '0;
            issued        <= '0;
            sent          <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else if (srst) begin
            blen          <= '0;
            issued        <= '0;
            sent          <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= acc;
            inflight_last <= acc && (issued == blen - cnt_t'(1));
            if (state == IDLE) begin
                issued <= '0;
                sent   <= '0;
                if (start_full)       blen <= BURST_LEN_C;
                else if (start_flush) blen <= fifo_rdused;
            end else begin
                if (acc) issued <= issued + cnt_t'(1);
                if (pop) sent   <= sent + cnt_t'(1);
            end
        end
    end

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .srst      (srst),
        .in_valid  (inflight),
        .in_data   (fifo_rddata),
        .in_last   (inflight_last),
        .out_valid (m_valid),
        .out_data  (m_data),
        .out_last  (m_last),
        .out_ready (m_ready),
        .occupancy (occupancy)
    );

`ifdef FIFO_BURST_READER_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_bursts <= '0;
            stat_stall  <= '0;
        end else if (srst) begin
            stat_bursts <= '0;
            stat_stall  <= '0;
        end else begin
            if (pop && m_last && stat_bursts != '1)
                stat_bursts <= stat_bursts + STAT_WIDTH'(1);
            if (state == BURST && !m_valid && stat_stall != '1)
                stat_stall <= stat_stall + STAT_WIDTH'(1);
        end
    end
`endif

endmodule
